branch_predictor: RTL and testbench

- Parametrised successor to the combinational branch unit. Adds a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Predicts next PC at fetch from registered table state.
- Takes resolved outcomes from the EX-stage branch unit, updates the table, and raises a registered one-cycle flush/redirect on misprediction.
- Keeps saturating branch and mispredict performance counters.

---
 rtl/branch_predictor_if.sv | 34 +++
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch, resolution and redirect signals of the branch predictor
interface branch_predictor_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic [PC_W-1:0]  i_fetch_PC;
  logic             o_pred_taken;
  logic [PC_W-1:0]  o_pred_target;
  logic             i_res_valid;
  logic             i_res_isBranch;
  logic [PC_W-1:0]  i_res_PC;
  logic             i_res_taken;
  logic [PC_W-1:0]  i_res_target;
  logic             i_res_predTaken;
  logic [PC_W-1:0]  i_res_predTarget;
  logic             o_flush;
  logic [PC_W-1:0]  o_redirectPC;
  logic [CNT_W-1:0] o_brCount;
  logic [CNT_W-1:0] o_missCount;

  // Pipeline side: drives fetch PC and resolved outcomes, consumes predictions.
  modport master (
    output i_fetch_PC, i_res_valid, i_res_isBranch, i_res_PC, i_res_taken,
           i_res_target, i_res_predTaken, i_res_predTarget,
    input  o_pred_taken, o_pred_target, o_flush, o_redirectPC, o_brCount, o_missCount
  );

  // Predictor side.
  modport slave (
    input  i_fetch_PC, i_res_valid, i_res_isBranch, i_res_PC, i_res_taken,
           i_res_target, i_res_predTaken, i_res_predTarget,
    output o_pred_taken, o_pred_target, o_flush, o_redirectPC, o_brCount, o_missCount
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters and mispredict redirect
module branch_predictor #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(4);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [PC_W-1:0]    tgt_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_d [ENTRIES];

  logic               flush_q, flush_d;
  logic [PC_W-1:0]    redir_q, redir_d;
  logic [CNT_W-1:0]   br_q, br_d;
  logic [CNT_W-1:0]   miss_q, miss_d;

  logic [IDX_W-1:0]   f_idx;
  logic               f_hit;
  logic               pred_taken;
  logic [IDX_W-1:0]   r_idx;
  logic               r_hit;
  logic               upd;
  logic               mispred;

  // Fetch lookup reads only registered table state, so an update in the same
  // cycle is seen by the fetch PC one cycle later (read-before-write).
  always_comb begin
    f_idx      = bp.i_fetch_PC[IDX_W+1:2];
    f_hit      = valid_q[f_idx] && (tag_q[f_idx] == bp.i_fetch_PC[PC_W-1:IDX_W+2]);
    pred_taken = f_hit && ctr_q[f_idx][CTR_W-1];
    bp.o_pred_taken  = pred_taken;
    bp.o_pred_target = pred_taken ? tgt_q[f_idx] : bp.i_fetch_PC + PC_STEP;
  end

  // Resolution: train the entry, detect mispredicts, step the perf counters.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    br_d    = br_q;
    miss_d  = miss_q;
    redir_d = redir_q;

    r_idx   = bp.i_res_PC[IDX_W+1:2];
    r_hit   = valid_q[r_idx] && (tag_q[r_idx] == bp.i_res_PC[PC_W-1:IDX_W+2]);
    upd     = bp.i_res_valid && bp.i_res_isBranch;
    mispred = upd && ((bp.i_res_taken != bp.i_res_predTaken) ||
                      (bp.i_res_taken && bp.i_res_predTaken &&
                       (bp.i_res_target != bp.i_res_predTarget)));

    if (upd) begin
      if (r_hit) begin
        if (bp.i_res_taken) begin
          if (ctr_q[r_idx] != CTR_MAX) ctr_d[r_idx] = ctr_q[r_idx] + CTR_W'(1);
          tgt_d[r_idx] = bp.i_res_target;
        end else if (ctr_q[r_idx] != '0) begin
          ctr_d[r_idx] = ctr_q[r_idx] - CTR_W'(1);
        end
      end else if (bp.i_res_taken) begin
        // A not-taken miss never allocates; a taken miss evicts whatever aliases here.
        valid_d[r_idx] = 1'b1;
        tag_d[r_idx]   = bp.i_res_PC[PC_W-1:IDX_W+2];
        tgt_d[r_idx]   = bp.i_res_target;
        ctr_d[r_idx]   = CTR_WEAK;
      end
      if (br_q != CNT_MAX) br_d = br_q + CNT_W'(1);
    end

    if (mispred && (miss_q != CNT_MAX)) miss_d = miss_q + CNT_W'(1);

    flush_d = mispred;
    if (mispred) redir_d = bp.i_res_taken ? bp.i_res_target : bp.i_res_PC + PC_STEP;
  end

  // State registers; reset wipes the table and kills any flush in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
      flush_q <= 1'b0;
      redir_q <= '0;
      br_q    <= '0;
      miss_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      br_q    <= br_d;
      miss_q  <= miss_d;
    end
  end

  assign bp.o_flush      = flush_q;
  assign bp.o_redirectPC = redir_q;
  assign bp.o_brCount    = br_q;
  assign bp.o_missCount  = miss_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor
module tb_branch_predictor;
  localparam int PC_W    = 32;
  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_SAT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  branch_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bp ();

  branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  always #5 clk = ~clk;

  // Reference model: each entry remembers the word address of the branch it
  // belongs to, a target, and a strength 0..3 (taken when >= 2).
  bit          m_valid [ENTRIES];
  logic [29:0] m_wpc   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_str   [ENTRIES];
  bit          m_flush;
  logic [31:0] m_redir;
  int          m_br;
  int          m_miss;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_pred(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
    int  e;
    bit  hit;
    e   = int'(pc[31:2]) % ENTRIES;
    hit = m_valid[e] && (m_wpc[e] == pc[31:2]);
    tk  = hit && (m_str[e] >= 2);
    tg  = tk ? m_tgt[e] : pc + 32'd4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0; m_wpc[i] = '0; m_tgt[i] = '0; m_str[i] = 0;
      end
      m_flush = 0; m_redir = '0; m_br = 0; m_miss = 0;
    end else begin
      bit mis;
      mis = 0;
      if (bp.i_res_valid && bp.i_res_isBranch) begin
        int e;
        bit hit;
        e   = int'(bp.i_res_PC[31:2]) % ENTRIES;
        hit = m_valid[e] && (m_wpc[e] == bp.i_res_PC[31:2]);
        if (bp.i_res_taken != bp.i_res_predTaken) mis = 1;
        if (bp.i_res_taken && bp.i_res_predTaken && bp.i_res_target != bp.i_res_predTarget) mis = 1;
        if (hit && bp.i_res_taken) begin
          m_str[e] = (m_str[e] < 3) ? m_str[e] + 1 : 3;
          m_tgt[e] = bp.i_res_target;
        end else if (hit) begin
          m_str[e] = (m_str[e] > 0) ? m_str[e] - 1 : 0;
        end else if (bp.i_res_taken) begin
          m_valid[e] = 1; m_wpc[e] = bp.i_res_PC[31:2]; m_tgt[e] = bp.i_res_target; m_str[e] = 2;
        end
        if (m_br < CNT_SAT) m_br++;
        if (mis && m_miss < CNT_SAT) m_miss++;
        if (mis) m_redir = bp.i_res_taken ? bp.i_res_target : bp.i_res_PC + 32'd4;
      end
      m_flush = mis;
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    bit          tk;
    logic [31:0] tg;
    model_pred(bp.i_fetch_PC, tk, tg);
    chk("pred_taken",  64'(bp.o_pred_taken),  64'(tk));
    chk("pred_target", 64'(bp.o_pred_target), 64'(tg));
    chk("flush",       64'(bp.o_flush),       64'(m_flush));
    chk("redirect",    64'(bp.o_redirectPC),  64'(m_redir));
    chk("br_count",    64'(bp.o_brCount),     64'(m_br));
    chk("miss_count",  64'(bp.o_missCount),   64'(m_miss));
  end

  task automatic idle();
    bp.i_res_valid = 0; bp.i_res_isBranch = 0; bp.i_res_PC = '0; bp.i_res_taken = 0;
    bp.i_res_target = '0; bp.i_res_predTaken = 0; bp.i_res_predTarget = '0;
  endtask

  task automatic res(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                     input bit ptk, input logic [31:0] ptg);
    bp.i_res_valid = 1; bp.i_res_isBranch = 1; bp.i_res_PC = pc; bp.i_res_taken = tk;
    bp.i_res_target = tg; bp.i_res_predTaken = ptk; bp.i_res_predTarget = ptg;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_pred(input string name, input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    bp.i_fetch_PC = pc;
    #1;
    chk({name, "_taken"},  64'(bp.o_pred_taken),  64'(tk));
    chk({name, "_target"}, 64'(bp.o_pred_target), 64'(tg));
  endtask

  task automatic lit_regs(input string name, input bit fl, input logic [31:0] rd, input int br, input int ms);
    chk({name, "_flush"}, 64'(bp.o_flush),      64'(fl));
    chk({name, "_redir"}, 64'(bp.o_redirectPC), 64'(rd));
    chk({name, "_br"},    64'(bp.o_brCount),    64'(br));
    chk({name, "_miss"},  64'(bp.o_missCount),  64'(ms));
  endtask

  initial begin
    idle();
    bp.i_fetch_PC = 32'h0040_0010;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    lit_pred("rst", 32'h0040_0010, 0, 32'h0040_0014);
    lit_regs("rst", 0, 32'h0, 0, 0);
    lit_pred("wrap", 32'hFFFF_FFFC, 0, 32'h0000_0000);

    // First taken branch: allocate weakly taken, mispredict
    cyc(); res(32'h0040_0010, 1, 32'h0040_0000, 0, 32'h0);
    cyc(); idle();
    lit_regs("alloc", 1, 32'h0040_0000, 1, 1);
    lit_pred("alloc", 32'h0040_0010, 1, 32'h0040_0000);
    cyc();
    lit_regs("pulse_end", 0, 32'h0040_0000, 1, 1);

    // Not taken against a taken prediction
    res(32'h0040_0010, 0, 32'h0, 1, 32'h0040_0000);
    cyc(); idle();
    lit_regs("nt_mis", 1, 32'h0040_0014, 2, 2);
    lit_pred("nt_mis", 32'h0040_0010, 0, 32'h0040_0014);

    // Four correctly predicted not-taken: counter floors at zero
    for (int i = 0; i < 4; i++) begin
      cyc(); res(32'h0040_0010, 0, 32'h0, 0, 32'h0);
    end
    cyc(); idle();
    lit_regs("nt_sat", 0, 32'h0040_0014, 6, 2);

    // Two taken resolutions bring the entry back to predicting taken
    for (int i = 0; i < 2; i++) begin
      cyc(); res(32'h0040_0010, 1, 32'h0040_0000, 0, 32'h0);
    end
    cyc(); idle();
    lit_pred("retrain", 32'h0040_0010, 1, 32'h0040_0000);
    lit_regs("retrain", 1, 32'h0040_0000, 8, 4);

    // Aliasing: not-taken miss does not allocate
    cyc(); res(32'h0040_0050, 0, 32'h0, 0, 32'h0);
    cyc(); idle();
    lit_pred("alias_keep", 32'h0040_0010, 1, 32'h0040_0000);
    lit_regs("alias_keep", 0, 32'h0040_0000, 9, 4);
    cyc(); res(32'h0040_0050, 1, 32'h0040_0080, 0, 32'h0);
    cyc(); idle();
    lit_pred("alias_old", 32'h0040_0010, 0, 32'h0040_0014);
    lit_pred("alias_new", 32'h0040_0050, 1, 32'h0040_0080);
    lit_regs("alias_new", 1, 32'h0040_0080, 10, 5);

    // Target mismatch with same-cycle lookup
    cyc(); res(32'h0040_0020, 1, 32'h0040_0100, 0, 32'h0);
    cyc(); res(32'h0040_0020, 1, 32'h0040_0200, 1, 32'h0040_0100);
    lit_pred("rbw_old", 32'h0040_0020, 1, 32'h0040_0100);
    cyc(); idle();
    lit_pred("rbw_new", 32'h0040_0020, 1, 32'h0040_0200);
    lit_regs("tgt_mis", 1, 32'h0040_0200, 12, 7);

    // Asynchronous reset in the middle of the flush pulse
    rst = 1;
    #1;
    lit_regs("async_rst", 0, 32'h0, 0, 0);
    rst = 0;
    cyc();
    lit_pred("post_rst_a", 32'h0040_0010, 0, 32'h0040_0014);
    lit_pred("post_rst_b", 32'h0040_0050, 0, 32'h0040_0054);
    lit_pred("post_rst_c", 32'h0040_0020, 0, 32'h0040_0024);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] pc, tg, ptg;
      bit          tk, ptk;
      cyc();
      if ($urandom_range(0, 399) == 0) begin
        rst = 1; #1; rst = 0;
      end
      pc = 32'h0040_0000 + ($urandom_range(0, 47) << 2) + $urandom_range(0, 3);
      tg = 32'h0040_0000 + ($urandom_range(0, 7) << 4);
      tk = $urandom_range(0, 2) != 0;
      model_pred(pc, ptk, ptg);
      if ($urandom_range(0, 9) < 3) begin
        ptk = $urandom_range(0, 1) != 0;
        if ($urandom_range(0, 1) != 0) ptg = 32'h0040_0000 + ($urandom_range(0, 7) << 4);
      end
      if ($urandom_range(0, 9) < 7) res(pc, tk, tg, ptk, ptg);
      else idle();
      if ($urandom_range(0, 9) == 0) bp.i_res_isBranch = 0;
      if ($urandom_range(0, 19) == 0)
        bp.i_fetch_PC = 32'hFFFF_FFFC + $urandom_range(0, 3);
      else if ($urandom_range(0, 3) == 0)
        bp.i_fetch_PC = pc;
      else
        bp.i_fetch_PC = 32'h0040_0000 + ($urandom_range(0, 47) << 2) + $urandom_range(0, 3);
    end
    cyc(); idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
